pi_controller_sat: RTL and testbench

- Incremental-form PI controller: u[n] = u[n-1] + KP*(e[n]-e[n-1]) + KI*e[n], with parametrised widths and a fixed-point scale shift.
- Runtime-loadable gains, valid handshake, output saturation with anti-windup (the stored state is always the clamped value).
- Three operating modes: RUN, HOLD, and MANUAL with bumpless transfer.
- Sits between the error subtractor and the actuator DAC in the laser control loop.

---
 rtl/pi_pkg.sv | 18 +
 rtl/sat_clamp.sv | 29 ++
 rtl/pi_controller_sat.sv | 143 ++++++++++++++
 tb/tb_pi_controller_sat.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pi_pkg.sv
// rtl/pi_pkg.sv - shared mode encodings and width helpers for the PI controller
package pi_pkg;

   localparam logic [1:0] MODE_RUN    = 2'b00;
   localparam logic [1:0] MODE_HOLD   = 2'b01;
   localparam logic [1:0] MODE_MANUAL = 2'b10;

   // Gain products: (GAIN_W+1) zero-extended gain times (DATA_W+1) error delta
   function automatic int prod_w(input int data_w, input int gain_w);
      return data_w + gain_w + 2;
   endfunction

   // Accumulator: one extra bit over the product so u_out + sum1 cannot overflow
   function automatic int acc_w(input int data_w, input int gain_w);
      return data_w + gain_w + 3;
   endfunction

endpackage

// File: rtl/sat_clamp.sv
// rtl/sat_clamp.sv - combinational clamp of a wide signed value into the output range
module sat_clamp #(
   parameter int IN_W  = 20,
   parameter int OUT_W = 9,
   parameter int MIN   = -256,
   parameter int MAX   = 255
) (
   input  logic signed [IN_W-1:0]  i_val,
   output logic signed [OUT_W-1:0] o_val,
   output logic                    o_hi,
   output logic                    o_lo
);

   localparam logic signed [IN_W-1:0] L_MAX = IN_W'(MAX);
   localparam logic signed [IN_W-1:0] L_MIN = IN_W'(MIN);

   // Compare against both rails and pick the rail or the in-range value
   always_comb begin
      o_hi  = (i_val > L_MAX);
      o_lo  = (i_val < L_MIN);
      o_val = OUT_W'(i_val);
      if (o_hi) begin
         o_val = OUT_W'(L_MAX);
      end else if (o_lo) begin
         o_val = OUT_W'(L_MIN);
      end
   end

endmodule

// File: rtl/pi_controller_sat.sv
// rtl/pi_controller_sat.sv - two-stage incremental PI controller with clamp and bumpless manual mode
module pi_controller_sat
   import pi_pkg::*;
#(
   parameter int DATA_W  = 9,
   parameter int GAIN_W  = 8,
   parameter int SHIFT   = 0,
   parameter int KP_RST  = 104,
   parameter int KI_RST  = 3,
   parameter int OUT_MAX = 2**(DATA_W-1) - 1,
   parameter int OUT_MIN = -(2**(DATA_W-1))
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] e_in,
   input  logic                     e_valid,
   input  logic [1:0]               mode,
   input  logic signed [DATA_W-1:0] u_manual,
   input  logic [GAIN_W-1:0]        kp_in,
   input  logic [GAIN_W-1:0]        ki_in,
   input  logic                     gain_load,
   output logic signed [DATA_W-1:0] u_out,
   output logic                     u_valid,
   output logic                     sat_hi,
   output logic                     sat_lo
);

   localparam int DE_W   = DATA_W + 1;
   localparam int PROD_W = prod_w(DATA_W, GAIN_W);
   localparam int ACC_W  = acc_w(DATA_W, GAIN_W);

   logic [GAIN_W-1:0]        r_kp;
   logic [GAIN_W-1:0]        r_ki;
   logic signed [DATA_W-1:0] r_e_prev;
   logic signed [PROD_W-1:0] r_sum1;
   logic [1:0]               r_mode;
   logic signed [DATA_W-1:0] r_man;
   logic                     r_v1;
   logic signed [DATA_W-1:0] r_u_out;
   logic                     r_u_valid;
   logic                     r_sat_hi;
   logic                     r_sat_lo;

   logic signed [DE_W-1:0]   w_de;
   logic signed [PROD_W-1:0] w_p;
   logic signed [PROD_W-1:0] w_i;
   logic signed [PROD_W-1:0] w_sum1;
   logic signed [ACC_W-1:0]  w_acc;
   logic signed [ACC_W-1:0]  w_clamp_in;
   logic signed [DATA_W-1:0] w_clamped;
   logic                     w_hi;
   logic                     w_lo;

   // Stage-1 arithmetic: error delta and the two gain products, gains treated as unsigned
   always_comb begin
      w_de   = DE_W'(e_in) - DE_W'(r_e_prev);
      w_p    = PROD_W'(signed'({1'b0, r_kp})) * PROD_W'(w_de);
      w_i    = PROD_W'(signed'({1'b0, r_ki})) * PROD_W'(e_in);
      w_sum1 = w_p + w_i;
   end

   // Gain registers; a sample on the same edge as a load still sees the old gains
   always_ff @(posedge clk) begin
      if (reset) begin
         r_kp <= GAIN_W'(KP_RST);
         r_ki <= GAIN_W'(KI_RST);
      end else if (gain_load) begin
         r_kp <= kp_in;
         r_ki <= ki_in;
      end
   end

   // Stage 1: capture the gain sum with its mode and manual value; e_prev tracks every mode
   always_ff @(posedge clk) begin
      if (reset) begin
         r_e_prev <= '0;
         r_sum1   <= '0;
         r_mode   <= MODE_RUN;
         r_man    <= '0;
         r_v1     <= 1'b0;
      end else begin
         r_v1 <= e_valid;
         if (e_valid) begin
            r_e_prev <= e_in;
            r_sum1   <= w_sum1;
            r_mode   <= mode;
            r_man    <= u_manual;
         end
      end
   end

   // Stage-2 candidate: integrate in RUN, take the manual value in MANUAL
   always_comb begin
      w_acc      = ACC_W'(r_u_out) + ACC_W'(r_sum1 >>> SHIFT);
      w_clamp_in = w_acc;
      if (r_mode == MODE_MANUAL) begin
         w_clamp_in = ACC_W'(r_man);
      end
   end

   sat_clamp #(
      .IN_W  (ACC_W),
      .OUT_W (DATA_W),
      .MIN   (OUT_MIN),
      .MAX   (OUT_MAX)
   ) u_sat_clamp (
      .i_val (w_clamp_in),
      .o_val (w_clamped),
      .o_hi  (w_hi),
      .o_lo  (w_lo)
   );

   // Stage 2: commit the clamped value so the integrator state never winds up past a rail
   always_ff @(posedge clk) begin
      if (reset) begin
         r_u_out   <= '0;
         r_u_valid <= 1'b0;
         r_sat_hi  <= 1'b0;
         r_sat_lo  <= 1'b0;
      end else begin
         r_u_valid <= r_v1;
         if (r_v1) begin
            case (r_mode)
               MODE_RUN, MODE_MANUAL: begin
                  r_u_out  <= w_clamped;
                  r_sat_hi <= w_hi;
                  r_sat_lo <= w_lo;
               end
               default: begin
                  r_sat_hi <= 1'b0;
                  r_sat_lo <= 1'b0;
               end
            endcase
         end
      end
   end

   assign u_out   = r_u_out;
   assign u_valid = r_u_valid;
   assign sat_hi  = r_sat_hi;
   assign sat_lo  = r_sat_lo;

endmodule

// File: tb/tb_pi_controller_sat.sv
// tb/tb_pi_controller_sat.sv - directed scoreboard bench for pi_controller_sat
module tb_pi_controller_sat;

   localparam int DATA_W = 9;
   localparam int GAIN_W = 8;

   logic                     clk = 1'b0;
   logic                     reset;
   logic signed [DATA_W-1:0] e_in;
   logic                     e_valid;
   logic [1:0]               mode;
   logic signed [DATA_W-1:0] u_manual;
   logic [GAIN_W-1:0]        kp_in;
   logic [GAIN_W-1:0]        ki_in;
   logic                     gain_load;
   logic signed [DATA_W-1:0] u_out;
   logic                     u_valid;
   logic                     sat_hi;
   logic                     sat_lo;

   pi_controller_sat dut (
      .clk       (clk),
      .reset     (reset),
      .e_in      (e_in),
      .e_valid   (e_valid),
      .mode      (mode),
      .u_manual  (u_manual),
      .kp_in     (kp_in),
      .ki_in     (ki_in),
      .gain_load (gain_load),
      .u_out     (u_out),
      .u_valid   (u_valid),
      .sat_hi    (sat_hi),
      .sat_lo    (sat_lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int    u;
      bit    hi;
      bit    lo;
      int    at;
      string tag;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Pop one expectation per u_valid pulse and check value, flags and arrival cycle
   always @(negedge clk) begin
      if (!reset && u_valid) begin
         total++;
         assert (q.size() != 0)
         else begin
            bad++;
            $error("FAIL unexpected_u_valid: u_out=%0d with no expected update", u_out);
         end
         if (q.size() != 0) begin
            exp_t x;
            x = q.pop_front();
            total++;
            assert (int'(u_out) === x.u)
            else begin
               bad++;
               $error("FAIL %s u_out: got %0d expected %0d", x.tag, u_out, x.u);
            end
            total++;
            assert (sat_hi === x.hi)
            else begin
               bad++;
               $error("FAIL %s sat_hi: got %0b expected %0b", x.tag, sat_hi, x.hi);
            end
            total++;
            assert (sat_lo === x.lo)
            else begin
               bad++;
               $error("FAIL %s sat_lo: got %0b expected %0b", x.tag, sat_lo, x.lo);
            end
            total++;
            assert (cyc === x.at)
            else begin
               bad++;
               $error("FAIL %s latency: got cycle %0d expected cycle %0d", x.tag, cyc, x.at);
            end
         end
      end
   end

   task automatic step(input int e, input logic [1:0] m, input int man,
                       input bit gl, input int kp, input int ki,
                       input bit chk, input int u, input bit hi, input bit lo,
                       input string tag);
      exp_t x;
      @(negedge clk);
      e_in      = e[DATA_W-1:0];
      e_valid   = 1'b1;
      mode      = m;
      u_manual  = man[DATA_W-1:0];
      gain_load = gl;
      kp_in     = kp[GAIN_W-1:0];
      ki_in     = ki[GAIN_W-1:0];
      if (chk) begin
         x.u = u; x.hi = hi; x.lo = lo; x.at = cyc + 2; x.tag = tag;
         q.push_back(x);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         e_valid   = 1'b0;
         gain_load = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      e_valid   = 1'b0;
      gain_load = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; e_in = '0; e_valid = 1'b0; mode = 2'b00; u_manual = '0;
      kp_in = '0; ki_in = '0; gain_load = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++;
      assert (u_out === 9'sd0 && u_valid === 1'b0 && sat_hi === 1'b0 && sat_lo === 1'b0)
      else begin
         bad++;
         $error("FAIL reset_state: u_out=%0d u_valid=%0b sat_hi=%0b sat_lo=%0b expected 0 0 0 0",
                u_out, u_valid, sat_hi, sat_lo);
      end

      // Step response, back to back
      step(1, 2'b00, 0, 0, 0, 0, 1, 107, 0, 0, "step1");
      step(1, 2'b00, 0, 0, 0, 0, 1, 110, 0, 0, "step2");
      step(1, 2'b00, 0, 0, 0, 0, 1, 113, 0, 0, "step3");
      idle(4);

      // Positive rail and recovery without windup
      do_reset();
      step(2, 2'b00, 0, 0, 0, 0, 1, 214, 0, 0, "sat_a");
      step(4, 2'b00, 0, 0, 0, 0, 1, 255, 1, 0, "sat_hi");
      step(2, 2'b00, 0, 0, 0, 0, 1, 53,  0, 0, "unwind");
      idle(4);

      // Negative rail
      do_reset();
      step(-3, 2'b00, 0, 0, 0, 0, 1, -256, 0, 1, "sat_lo");
      idle(4);

      // HOLD, reserved mode, MANUAL, bumpless return to RUN
      do_reset();
      step(1, 2'b00, 0,  0, 0, 0, 1, 107, 0, 0, "run");
      step(5, 2'b01, 0,  0, 0, 0, 1, 107, 0, 0, "hold");
      step(5, 2'b11, 0,  0, 0, 0, 1, 107, 0, 0, "mode11");
      step(5, 2'b10, 50, 0, 0, 0, 1, 50,  0, 0, "manual");
      step(5, 2'b00, 0,  0, 0, 0, 1, 65,  0, 0, "bumpless");
      idle(4);

      // Gain load on the same edge as a sample uses the old gains
      do_reset();
      step(1, 2'b00, 0, 1, 0, 1, 1, 107, 0, 0, "gain_old");
      step(1, 2'b00, 0, 0, 0, 0, 1, 108, 0, 0, "gain_new");
      idle(4);

      // Reset right after a sample is accepted discards it
      do_reset();
      step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, "dropped");
      @(negedge clk);
      reset   = 1'b1;
      e_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      idle(3);
      total++;
      assert (u_out === 9'sd0)
      else begin
         bad++;
         $error("FAIL midreset_u_out: got %0d expected 0", u_out);
      end
      step(1, 2'b00, 0, 0, 0, 0, 1, 107, 0, 0, "after_reset");
      idle(6);

      total++;
      assert (q.size() == 0)
      else begin
         bad++;
         $error("FAIL missing_updates: %0d expected updates never arrived", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
